store_write_buffer: RTL and testbench

- FIFO store buffer sitting directly upstream of the byte-addressed data memory, between the EX/MEM pipeline register and the memory port.
- Decouples MEM-stage stores from the single shared memory address port: stores are queued and drained one per cycle whenever the port is not needed by a load.
- Loads are checked against queued stores: exact-address hits are forwarded, partial overlaps stall the load until the conflicting stores drain.

---
 rtl/store_write_buffer.sv | 102 ++++++++++
 tb/tb_store_write_buffer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/store_write_buffer.sv
// store_write_buffer: FIFO store buffer in front of the shared data-memory port.
// Loads are checked against queued stores and either forwarded or stalled.
// Optional feature macro STB_FORWARD_EN: when defined, exact-address loads are
// forwarded from the youngest matching entry; when undefined, every overlap stalls.
// Ports: clk/reset (sync, active-high); st_valid/st_addr/st_data/st_ready (store in);
// ld_valid/ld_addr/ld_hit/ld_hit_data/ld_stall (load check); mem_Addr/mem_Write_Data/
// mem_MemWrite/mem_MemRead (memory port); count/empty (occupancy).
module store_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       st_valid,
    input  logic [ADDR_W-1:0]          st_addr,
    input  logic [DATA_W-1:0]          st_data,
    output logic                       st_ready,
    input  logic                       ld_valid,
    input  logic [ADDR_W-1:0]          ld_addr,
    output logic                       ld_hit,
    output logic [DATA_W-1:0]          ld_hit_data,
    output logic                       ld_stall,
    output logic [ADDR_W-1:0]          mem_Addr,
    output logic [DATA_W-1:0]          mem_Write_Data,
    output logic                       mem_MemWrite,
    output logic                       mem_MemRead,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    logic [ADDR_W-1:0] e_addr [DEPTH];
    logic [DATA_W-1:0] e_data [DEPTH];
    logic [DEPTH-1:0]  e_valid;
    logic [PW-1:0]     head, tail, idx;
    logic [ADDR_W:0]   ld_lo, ld_hi, e_lo, e_hi;
    logic              full, push, pop, rd, ov, ex, any_part, any_exact;
    logic [DATA_W-1:0] fwd_data;
    // Overlap bounds are widened by one bit so addr+8 cannot wrap near the top.
    assign ld_lo = {1'b0, ld_addr};
    assign ld_hi = ld_lo + (ADDR_W+1)'(8);
    // Scan oldest to youngest so the last exact match seen is the youngest.
    always_comb begin
        any_part  = 1'b0;
        any_exact = 1'b0;
        fwd_data  = '0;
        idx       = head;
        e_lo      = '0;
        e_hi      = '0;
        ov        = 1'b0;
        ex        = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            idx       = head + PW'(k);
            e_lo      = {1'b0, e_addr[idx]};
            e_hi      = e_lo + (ADDR_W+1)'(8);
            ov        = e_valid[idx] && (ld_lo < e_hi) && (e_lo < ld_hi);
            ex        = ov && (ld_addr == e_addr[idx]);
            any_part  = any_part | (ov && !ex);
            any_exact = any_exact | ex;
            fwd_data  = ex ? e_data[idx] : fwd_data;
        end
    end
`ifdef STB_FORWARD_EN
    assign ld_stall = ld_valid && any_part;
    assign ld_hit   = ld_valid && !any_part && any_exact;
`else
    assign ld_stall = ld_valid && (any_part || any_exact);
    assign ld_hit   = 1'b0;
`endif
    assign ld_hit_data    = fwd_data;
    assign full           = count == (PW+1)'(DEPTH);
    assign empty          = count == '0;
    assign st_ready       = !full;
    assign push           = st_valid && !full;
    // A load that must go to memory owns the port; otherwise the head drains.
    assign rd             = ld_valid && !ld_stall && !ld_hit;
    assign pop            = !rd && !empty;
    assign mem_MemRead    = rd;
    assign mem_MemWrite   = pop;
    assign mem_Addr       = pop ? e_addr[head] : ld_addr;
    assign mem_Write_Data = e_data[head];
    always_ff @(posedge clk) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            e_valid <= '0;
        end else begin
            if (push) begin
                e_addr[tail]  <= st_addr;
                e_data[tail]  <= st_data;
                e_valid[tail] <= 1'b1;
                tail          <= tail + 1'b1;
            end
            if (pop) begin
                e_valid[head] <= 1'b0;
                head          <= head + 1'b1;
            end
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_store_write_buffer.sv
// tb_store_write_buffer: directed self-checking bench for store_write_buffer.
module tb_store_write_buffer;
    logic        clk = 1'b0;
    logic        reset, st_valid, st_ready, ld_valid, ld_hit, ld_stall;
    logic        mem_MemWrite, mem_MemRead, empty;
    logic [63:0] st_addr, st_data, ld_addr, ld_hit_data, mem_Addr, mem_Write_Data;
    logic [2:0]  count;
    logic [63:0] wa_q[$], wd_q[$];
    int checks = 0, errors = 0;

    store_write_buffer #(.DEPTH(4), .ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_hit_data(ld_hit_data),
        .ld_stall(ld_stall), .mem_Addr(mem_Addr), .mem_Write_Data(mem_Write_Data),
        .mem_MemWrite(mem_MemWrite), .mem_MemRead(mem_MemRead), .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    // Memory commits writes on the negedge; record them in order.
    always @(negedge clk) if (!reset && mem_MemWrite) begin
        wa_q.push_back(mem_Addr);
        wd_q.push_back(mem_Write_Data);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1; st_valid = 0; ld_valid = 0; st_addr = 0; st_data = 0; ld_addr = 0;
        tick; tick;
        reset = 0;
        @(negedge clk);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b exp 1", empty); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL reset_st_ready got %0b exp 1", st_ready); end
        checks++; if (mem_MemWrite !== 1'b0) begin errors++; $display("FAIL reset_memwrite got %0b exp 0", mem_MemWrite); end
        checks++; if (ld_hit !== 1'b0) begin errors++; $display("FAIL reset_ld_hit got %0b exp 0", ld_hit); end
        checks++; if (ld_stall !== 1'b0) begin errors++; $display("FAIL reset_ld_stall got %0b exp 0", ld_stall); end
        tick;
    endtask

    task automatic test_fill_drain;
        wa_q.delete(); wd_q.delete();
        ld_valid = 1; ld_addr = 512;
        for (int i = 0; i < 4; i++) begin
            st_valid = 1; st_addr = 64'(256 + 8 * i); st_data = 64'(17 * (i + 1));
            @(negedge clk);
            checks++; if ({mem_MemRead, mem_MemWrite} !== 2'b10) begin errors++; $display("FAIL fill_port_%0d got rd=%0b wr=%0b exp rd=1 wr=0", i, mem_MemRead, mem_MemWrite); end
            tick;
        end
        st_addr = 288; st_data = 64'h55;
        @(negedge clk);
        checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL full_st_ready got %0b exp 0", st_ready); end
        tick;
        st_valid = 0; ld_valid = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (count !== 3'(4 - i)) begin errors++; $display("FAIL drain_count_%0d got %0d exp %0d", i, count, 4 - i); end
            checks++; if (mem_MemWrite !== 1'b1 || mem_Addr !== 64'(256 + 8 * i) || mem_Write_Data !== 64'(17 * (i + 1)))
                begin errors++; $display("FAIL drain_%0d got wr=%0b addr=%0d data=%h exp wr=1 addr=%0d data=%h", i, mem_MemWrite, mem_Addr, mem_Write_Data, 256 + 8 * i, 17 * (i + 1)); end
            tick;
        end
        @(negedge clk);
        checks++; if (empty !== 1'b1 || mem_MemWrite !== 1'b0) begin errors++; $display("FAIL drain_done got empty=%0b wr=%0b exp empty=1 wr=0", empty, mem_MemWrite); end
        checks++; if (wa_q.size() !== 4) begin errors++; $display("FAIL drain_log_size got %0d exp 4", wa_q.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++; if (wa_q[i] !== 64'(256 + 8 * i) || wd_q[i] !== 64'(17 * (i + 1)))
                begin errors++; $display("FAIL mem_log_%0d got addr=%0d data=%h exp addr=%0d data=%h", i, wa_q[i], wd_q[i], 256 + 8 * i, 17 * (i + 1)); end
        end
        tick;
    endtask

    task automatic test_forward;
        wa_q.delete(); wd_q.delete();
        ld_valid = 1; ld_addr = 512;
        st_valid = 1; st_addr = 264; st_data = 64'hAA; tick;
        st_data = 64'hBB; tick;
        st_valid = 0; ld_addr = 264;
`ifdef STB_FORWARD_EN
        @(negedge clk);
        checks++; if (ld_hit !== 1'b1 || ld_hit_data !== 64'hBB) begin errors++; $display("FAIL fwd_hit got hit=%0b data=%h exp hit=1 data=bb", ld_hit, ld_hit_data); end
        checks++; if (mem_MemRead !== 1'b0 || ld_stall !== 1'b0) begin errors++; $display("FAIL fwd_port got rd=%0b stall=%0b exp 0 0", mem_MemRead, ld_stall); end
        tick;
        @(negedge clk);
        checks++; if (ld_hit !== 1'b1 || ld_hit_data !== 64'hBB || count !== 3'd1) begin errors++; $display("FAIL fwd_hit2 got hit=%0b data=%h count=%0d exp 1 bb 1", ld_hit, ld_hit_data, count); end
        tick;
`else
        @(negedge clk);
        checks++; if (ld_stall !== 1'b1 || ld_hit !== 1'b0 || count !== 3'd2) begin errors++; $display("FAIL nofwd_stall0 got stall=%0b hit=%0b count=%0d exp 1 0 2", ld_stall, ld_hit, count); end
        tick;
        @(negedge clk);
        checks++; if (ld_stall !== 1'b1 || count !== 3'd1) begin errors++; $display("FAIL nofwd_stall1 got stall=%0b count=%0d exp 1 1", ld_stall, count); end
        tick;
        @(negedge clk);
        checks++; if (ld_stall !== 1'b0 || mem_MemRead !== 1'b1 || mem_Addr !== 64'd264) begin errors++; $display("FAIL nofwd_read got stall=%0b rd=%0b addr=%0d exp 0 1 264", ld_stall, mem_MemRead, mem_Addr); end
        tick;
`endif
        ld_valid = 0;
        @(negedge clk);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fwd_empty got %0b exp 1", empty); end
        checks++; if (wd_q.size() !== 2 || wd_q[0] !== 64'hAA || wd_q[1] !== 64'hBB) begin errors++; $display("FAIL fwd_order got n=%0d exp AA then BB", wd_q.size()); end
        tick;
    endtask

    task automatic test_partial;
        ld_valid = 0; st_valid = 1; st_addr = 256; st_data = 64'h77; tick;
        st_valid = 0; ld_valid = 1; ld_addr = 260;
        @(negedge clk);
        checks++; if (ld_stall !== 1'b1 || ld_hit !== 1'b0) begin errors++; $display("FAIL part_stall got stall=%0b hit=%0b exp 1 0", ld_stall, ld_hit); end
        checks++; if (mem_MemWrite !== 1'b1 || mem_Addr !== 64'd256) begin errors++; $display("FAIL part_drain got wr=%0b addr=%0d exp 1 256", mem_MemWrite, mem_Addr); end
        tick;
        @(negedge clk);
        checks++; if (ld_stall !== 1'b0 || mem_MemRead !== 1'b1 || mem_Addr !== 64'd260) begin errors++; $display("FAIL part_read got stall=%0b rd=%0b addr=%0d exp 0 1 260", ld_stall, mem_MemRead, mem_Addr); end
        tick;
        ld_valid = 0;
    endtask

    task automatic test_back_to_back;
        logic [63:0] ea[5], ed[5];
        ea = '{1024, 1032, 1040, 1048, 1064};
        ed = '{64'h100, 64'h101, 64'h102, 64'h103, 64'hA0};
        wa_q.delete(); wd_q.delete();
        ld_valid = 1; ld_addr = 512;
        for (int i = 0; i < 4; i++) begin
            st_valid = 1; st_addr = ea[i]; st_data = ed[i]; tick;
        end
        ld_valid = 0; st_addr = 1056; st_data = 64'h99;
        @(negedge clk);
        checks++; if (st_ready !== 1'b0 || mem_MemWrite !== 1'b1 || count !== 3'd4) begin errors++; $display("FAIL full_pushpop got ready=%0b wr=%0b count=%0d exp 0 1 4", st_ready, mem_MemWrite, count); end
        tick;
        st_valid = 0;
        @(negedge clk);
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_refused_count got %0d exp 3", count); end
        tick;
        st_valid = 1; st_addr = 1064; st_data = 64'hA0;
        @(negedge clk);
        checks++; if (count !== 3'd2 || st_ready !== 1'b1 || mem_MemWrite !== 1'b1) begin errors++; $display("FAIL wrap_pushpop got count=%0d ready=%0b wr=%0b exp 2 1 1", count, st_ready, mem_MemWrite); end
        tick;
        st_valid = 0;
        @(negedge clk);
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL wrap_count got %0d exp 2", count); end
        tick; tick;
        @(negedge clk);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %0b exp 1", empty); end
        checks++; if (wa_q.size() !== 5) begin errors++; $display("FAIL wrap_log_size got %0d exp 5", wa_q.size()); end
        else for (int i = 0; i < 5; i++) begin
            checks++; if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i])
                begin errors++; $display("FAIL wrap_log_%0d got addr=%0d data=%h exp addr=%0d data=%h", i, wa_q[i], wd_q[i], ea[i], ed[i]); end
        end
        tick;
    endtask

    task automatic test_reset_mid;
        ld_valid = 1; ld_addr = 512;
        for (int i = 0; i < 3; i++) begin
            st_valid = 1; st_addr = 64'(2048 + 8 * i); st_data = 64'(i + 1); tick;
        end
        st_valid = 0; reset = 1;
        @(negedge clk);
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL pre_reset_count got %0d exp 3", count); end
        tick;
        reset = 0; ld_valid = 0;
        wa_q.delete(); wd_q.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (empty !== 1'b1 || mem_MemWrite !== 1'b0) begin errors++; $display("FAIL mid_reset_%0d got empty=%0b wr=%0b exp 1 0", i, empty, mem_MemWrite); end
            tick;
        end
        checks++; if (wa_q.size() !== 0) begin errors++; $display("FAIL mid_reset_log got %0d writes exp 0", wa_q.size()); end
    endtask

    initial begin
        test_reset;
        test_fill_drain;
        test_forward;
        test_partial;
        test_back_to_back;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
